// File: rtl/gpu_pkg.sv
// Shared constants, op codes, GPU FSM states and pixel addressing for fb_mem.
// FB_CLEAR_EN adds the full-screen clear state.
package gpu_pkg;
   localparam int FB_W           = 320;
   localparam int FB_H           = 200;
   localparam int WORD_W         = 16;
   localparam int WORDS_PER_LINE = 20;
   localparam int FB_WORDS       = 4000;
   localparam int ADDR_W         = 13;

   typedef enum logic [1:0] {
      OP_CLR = 2'b00,
      OP_SET = 2'b01,
      OP_XOR = 2'b10,
      OP_RD  = 2'b11
   } op_code_e;

`ifdef FB_CLEAR_EN
   typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WAIT, ST_MOD, ST_CLR} gpu_state_e;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WAIT, ST_MOD} gpu_state_e;
`endif

   // y*20 + x/16, built from shifts so it maps onto adders only
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
      logic [ADDR_W-1:0] yy;
      yy = {5'd0, y};
      return (yy << 4) + (yy << 2) + {8'd0, x[8:4]};
   endfunction

   function automatic logic in_range(input logic [8:0] x, input logic [7:0] y);
      return (x < 9'(FB_W)) && (y < 8'(FB_H));
   endfunction
endpackage

// File: rtl/fb_ram.sv
// Single-port synchronous RAM, 4000 x 16, one-cycle registered read.
module fb_ram
   import gpu_pkg::*;
(
   input  logic              clk,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o
);
   logic [WORD_W-1:0] mem_q [FB_WORDS];

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) mem_q[addr_i] <= wdata_i;
         else      rdata_o       <= mem_q[addr_i];
      end
   end
endmodule

// File: rtl/fb_mem.sv
// 320x200 1bpp framebuffer: video fetches pre-empt GPU read-modify-write ops on one
// single-port RAM. Define FB_CLEAR_EN to enable the (511,255) full-screen clear.
module fb_mem
   import gpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] x_a,
   input  logic [7:0] y_a,
   output logic       in_a,
   input  logic       op_valid,
   output logic       op_ready,
   input  logic [8:0] op_x,
   input  logic [7:0] op_y,
   input  logic [1:0] op_code,
   output logic       rd_data,
   output logic       rd_valid,
   output logic       busy
);
   logic [ADDR_W-1:0] req_addr_q, tag_q;
   logic [3:0]        req_bit_q, s2_bit_q;
   logic              req_inr_q, s2_inr_q, s2_miss_q, tag_vld_q, in_a_q;
   logic [WORD_W-1:0] held_q, held_d;
   logic              vid_miss, in_a_d;

   gpu_state_e        state_q;
   op_code_e          op_q;
   logic [ADDR_W-1:0] op_addr_q;
   logic [3:0]        op_bit_q;
   logic [WORD_W-1:0] word_q, mod_word;
   logic              op_ready_q, rd_data_q, rd_valid_q, busy_q;
   logic              gpu_rd_go, gpu_wr_go, clr_go, clr_fin;

   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [WORD_W-1:0] ram_wdata, ram_rdata;
`ifdef FB_CLEAR_EN
   logic [ADDR_W-1:0] clr_addr_q;
`endif

   assign vid_miss = req_inr_q && !(tag_vld_q && (tag_q == req_addr_q));

   always_comb begin
      gpu_rd_go = (state_q == ST_RD)  && !vid_miss;
      gpu_wr_go = (state_q == ST_MOD) && !vid_miss;
`ifdef FB_CLEAR_EN
      clr_go    = (state_q == ST_CLR) && !vid_miss;
      clr_fin   = clr_go && (clr_addr_q == ADDR_W'(FB_WORDS - 1));
`else
      clr_go    = 1'b0;
      clr_fin   = 1'b0;
`endif
      mod_word = word_q;
      case (op_q)
         OP_CLR:  mod_word[op_bit_q] = 1'b0;
         OP_SET:  mod_word[op_bit_q] = 1'b1;
         OP_XOR:  mod_word[op_bit_q] = ~word_q[op_bit_q];
         default: mod_word = word_q;
      endcase
      ram_en    = vid_miss | gpu_rd_go | gpu_wr_go | clr_go;
      ram_we    = gpu_wr_go | clr_go;
      ram_addr  = vid_miss ? req_addr_q : op_addr_q;
      ram_wdata = mod_word;
`ifdef FB_CLEAR_EN
      if (clr_go) begin
         ram_addr  = clr_addr_q;
         ram_wdata = '0;
      end
`endif
      // Any write to the tagged word also lands in the held copy, so a hit never sees stale data
      held_d = s2_miss_q ? ram_rdata : held_q;
      if (ram_we && (ram_addr == tag_q)) held_d = ram_wdata;
      in_a_d = s2_inr_q && (s2_miss_q ? ram_rdata[s2_bit_q] : held_q[s2_bit_q]);
   end

   fb_ram u_ram (
      .clk     (clk),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_addr_q <= '0;
         req_bit_q  <= '0;
         req_inr_q  <= 1'b0;
         s2_bit_q   <= '0;
         s2_inr_q   <= 1'b0;
         s2_miss_q  <= 1'b0;
         tag_q      <= '0;
         tag_vld_q  <= 1'b0;
         held_q     <= '0;
         in_a_q     <= 1'b0;
      end else begin
         req_addr_q <= pix_addr(x_a, y_a);
         req_bit_q  <= x_a[3:0];
         req_inr_q  <= in_range(x_a, y_a);
         s2_bit_q   <= req_bit_q;
         s2_inr_q   <= req_inr_q;
         s2_miss_q  <= vid_miss;
         held_q     <= held_d;
         in_a_q     <= in_a_d;
         if (vid_miss) begin
            tag_q     <= req_addr_q;
            tag_vld_q <= 1'b1;
         end
         if (clr_fin) tag_vld_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_CLR;
         op_addr_q  <= '0;
         op_bit_q   <= '0;
         word_q     <= '0;
         op_ready_q <= 1'b0;
         rd_data_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef FB_CLEAR_EN
         clr_addr_q <= '0;
`endif
      end else begin
         rd_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               op_ready_q <= 1'b1;
               busy_q     <= 1'b0;
               if (op_valid && op_ready_q) begin
                  op_q      <= op_code_e'(op_code);
                  op_addr_q <= pix_addr(op_x, op_y);
                  op_bit_q  <= op_x[3:0];
`ifdef FB_CLEAR_EN
                  if ((op_code_e'(op_code) == OP_CLR) && (op_x == 9'd511) && (op_y == 8'd255)) begin
                     state_q    <= ST_CLR;
                     clr_addr_q <= '0;
                     op_ready_q <= 1'b0;
                     busy_q     <= 1'b1;
                  end else
`endif
                  if (in_range(op_x, op_y)) begin
                     state_q    <= ST_RD;
                     op_ready_q <= 1'b0;
                     busy_q     <= 1'b1;
                  end else if (op_code_e'(op_code) == OP_RD) begin
                     rd_valid_q <= 1'b1;
                     rd_data_q  <= 1'b0;
                  end
               end
            end
            ST_RD: if (gpu_rd_go) state_q <= ST_WAIT;
            ST_WAIT: begin
               word_q <= ram_rdata;
               if (op_q == OP_RD) begin
                  rd_valid_q <= 1'b1;
                  rd_data_q  <= ram_rdata[op_bit_q];
                  state_q    <= ST_IDLE;
                  op_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
               end else begin
                  state_q <= ST_MOD;
               end
            end
            ST_MOD: if (gpu_wr_go) begin
               state_q    <= ST_IDLE;
               op_ready_q <= 1'b1;
               busy_q     <= 1'b0;
            end
`ifdef FB_CLEAR_EN
            ST_CLR: if (clr_go) begin
               if (clr_fin) begin
                  state_q    <= ST_IDLE;
                  op_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
               end else begin
                  clr_addr_q <= clr_addr_q + 1'b1;
               end
            end
`endif
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_a     = in_a_q;
   assign op_ready = op_ready_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign busy     = busy_q;
endmodule

// File: tb/tb_fb_mem.sv
// Randomized scoreboard bench for fb_mem: video samples and GPU reads are checked
// against a pixel-array model; FB_CLEAR_EN also exercises the full-screen clear.
module tb_fb_mem;
   localparam logic [1:0] C_CLR = 2'b00, C_SET = 2'b01, C_XOR = 2'b10, C_RD = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [8:0] x_a = 9'd320;
   logic [7:0] y_a = 8'd0;
   logic       in_a;
   logic       op_valid = 1'b0;
   logic       op_ready;
   logic [8:0] op_x = '0;
   logic [7:0] op_y = '0;
   logic [1:0] op_code = '0;
   logic       rd_data, rd_valid, busy;

   fb_mem dut (
      .clk(clk), .rst(rst), .x_a(x_a), .y_a(y_a), .in_a(in_a),
      .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x), .op_y(op_y),
      .op_code(op_code), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   bit fb [200][320];
   typedef struct { bit exp; int x; int y; } vid_t;
   vid_t vq[$];
   bit   rq[$];
   int   checks = 0, errors = 0, cyc = 0;
   int   vx = 320, vy = 0;
   int   xs[$], ys[$];

   function automatic bit model_px(input int x, input int y);
      if (x < 320 && y < 200) return fb[y][x];
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Video driver: the address driven at a negedge is sampled next posedge; its pixel is due two posedges later
   always @(negedge clk) begin
      vid_t e;
      x_a = 9'(vx);
      y_a = 8'(vy);
      e.exp = model_px(vx, vy);
      e.x = vx;
      e.y = vy;
      vq.push_back(e);
   end

   always @(posedge clk) begin
      vid_t e;
      bit   r;
      #1;
      if (vq.size() >= 3) begin
         e = vq.pop_front();
         checks++;
         if (in_a !== e.exp) begin
            errors++;
            $display("FAIL video (%0d,%0d) in_a=%0b expected=%0b", e.x, e.y, in_a, e.exp);
         end
      end
      if (rd_valid) begin
         checks++;
         if (rq.size() == 0) begin
            errors++;
            $display("FAIL rd_valid unexpected rd_data=%0b expected=no strobe", rd_data);
         end else begin
            r = rq.pop_front();
            if (rd_data !== r) begin
               errors++;
               $display("FAIL read rd_data=%0b expected=%0b", rd_data, r);
            end
         end
      end
   end

   // Called just after a posedge; returns just after the handshake posedge
   task automatic do_op(input int x, input int y, input logic [1:0] code, input bit apply);
      int n = 0;
      op_x = 9'(x);
      op_y = 8'(y);
      op_code = code;
      op_valid = 1'b1;
      while (!op_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (!op_ready) begin
         chk("op_handshake_timeout", op_ready, 1'b1);
         op_valid = 1'b0;
         return;
      end
      if (apply) begin
         if (code == C_CLR && x == 511 && y == 255) begin
`ifdef FB_CLEAR_EN
            foreach (fb[i, j]) fb[i][j] = 1'b0;
`endif
         end else if (x < 320 && y < 200) begin
            case (code)
               C_CLR: fb[y][x] = 1'b0;
               C_SET: fb[y][x] = 1'b1;
               C_XOR: fb[y][x] = ~fb[y][x];
               default: rq.push_back(fb[y][x]);
            endcase
         end else if (code == C_RD) begin
            rq.push_back(1'b0);
         end
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (!op_ready && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      if (!op_ready) chk("idle_timeout", op_ready, 1'b1);
   endtask

   task automatic hold(input int x, input int y, input int cycles);
      vx = x;
      vy = y;
      repeat (cycles) begin @(posedge clk); #1; end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, n, x, y;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_a", in_a, 1'b0);
      chk("rst_op_ready", op_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_rd_data", rd_data, 1'b0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_op_ready", op_ready, 1'b1);

      // basic set / read
      do_op(5, 3, C_SET, 1);
      chk("busy_after_accept", busy, 1'b1);
      do_op(5, 3, C_RD, 1);
      do_op(6, 3, C_RD, 1);
      wait_idle(50);

      // throughput: 4 cycles per write, 3 per read, no video contention
      do_op(7, 4, C_SET, 1); t0 = cyc;
      do_op(8, 4, C_SET, 1);
      do_op(9, 4, C_XOR, 1);
      do_op(10, 4, C_CLR, 1); t1 = cyc;
      chk_int("write_op_rate", t1 - t0, 12);
      do_op(7, 4, C_RD, 1); t0 = cyc;
      do_op(8, 4, C_RD, 1);
      do_op(9, 4, C_RD, 1);
      do_op(10, 4, C_RD, 1); t1 = cyc;
      chk_int("read_op_rate", t1 - t0, 9);
      wait_idle(50);

      // video latency and write-through to the held word
      hold(20, 0, 4);
      do_op(17, 0, C_SET, 1);
      do_op(18, 0, C_SET, 1);
      wait_idle(50);
      for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 17 : 16, 0, 1);
      hold(18, 0, 2);
      hold(320, 0, 2);

      // prefill line 50, then sweep it while XORs land elsewhere
      for (int i = 0; i < 24; i++) do_op($urandom_range(0, 319), 50, C_SET, 1);
      wait_idle(50);
      vy = 50;
      fork
         begin
            for (int sx = 0; sx <= 320; sx++) hold(sx, 50, 2);
         end
         begin
            for (int i = 0; i < 80; i++) begin
               x = $urandom_range(0, 319);
               y = $urandom_range(0, 198);
               if (y >= 50) y++;
               xs.push_back(x);
               ys.push_back(y);
               do_op(x, y, C_XOR, 1);
            end
         end
      join
      wait_idle(50);
      hold(320, 0, 2);
      foreach (xs[i]) do_op(xs[i], ys[i], C_RD, 1);
      wait_idle(50);

      // double XOR, edge pixel, out-of-range ops
      do_op(100, 199, C_XOR, 1);
      do_op(100, 199, C_RD, 1);
      do_op(100, 199, C_XOR, 1);
      do_op(100, 199, C_RD, 1);
      do_op(319, 199, C_SET, 1);
      wait_idle(50);
      hold(319, 199, 3);
      hold(320, 199, 3);
      do_op(0, 1, C_CLR, 1);
      do_op(320, 0, C_SET, 1);
      chk("oor_stays_ready", op_ready, 1'b1);
      do_op(0, 200, C_SET, 1);
      do_op(320, 0, C_RD, 1);
      do_op(0, 200, C_RD, 1);
      do_op(0, 1, C_RD, 1);
      wait_idle(50);

      // reset while a SET sits in its write state
      hold(320, 0, 1);
      do_op(40, 10, C_SET, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mod_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("midrst_op_ready", op_ready, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      @(posedge clk); #1;
      chk("midrst_hold_op_ready", op_ready, 1'b0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("postrst_op_ready", op_ready, 1'b1);
      do_op(40, 10, C_RD, 1);
      do_op(41, 10, C_RD, 1);
      wait_idle(50);

`ifdef FB_CLEAR_EN
      for (int i = 0; i < 10; i++) do_op($urandom_range(0, 319), $urandom_range(0, 199), C_SET, 1);
      do_op(12, 20, C_SET, 1);
      wait_idle(50);
      hold(12, 20, 4);
      hold(320, 0, 3);
      do_op(511, 255, C_CLR, 1);
      n = 0;
      while (busy && n < 20000) begin
         if (op_ready) chk("clr_op_ready", op_ready, 1'b0);
         @(posedge clk); #1;
         n++;
      end
      chk("clr_busy_long", (n >= 4000) && (n < 20000), 1'b1);
      wait_idle(50);
      hold(12, 20, 3);
      hold(5, 3, 3);
      hold(320, 0, 2);
      do_op(12, 20, C_RD, 1);
      do_op(5, 3, C_RD, 1);
      foreach (xs[i]) if (i < 10) do_op(xs[i], ys[i], C_RD, 1);
      wait_idle(50);
`else
      do_op(511, 255, C_CLR, 1);
      do_op(5, 3, C_RD, 1);
      do_op(17, 0, C_RD, 1);
      wait_idle(50);
`endif

      repeat (4) begin @(posedge clk); #1; end
      chk_int("reads_drained", rq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
